mpu_seq_matmul: RTL and testbench



---
 rtl/mpu_pkg.sv | 38 +++
 rtl/mpu_mac.sv | 59 +++++
 rtl/mpu_seq_matmul.sv | 186 ++++++++++++++++++
 tb/tb_mpu_seq_matmul.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mpu_pkg
// Description : Shared types and helpers for the sequential matrix unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mpu_pkg;

   typedef enum logic [1:0] {
      MODE_MUL = 2'd0,
      MODE_ADD = 2'd1,
      MODE_SUB = 2'd2,
      MODE_HAD = 2'd3
   } mpu_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mpu_state_t;

   localparam int c_DATA_W_DEF = 8;
   localparam int c_MAX_N_DEF  = 5;

   // Exact accumulator: full product plus headroom for summing MAX_N terms
   function automatic int acc_exact_w(input int data_w, input int max_n);
      return 2 * data_w + $clog2(max_n);
   endfunction

   localparam int c_ACC_EXACT_W_DEF = acc_exact_w(c_DATA_W_DEF, c_MAX_N_DEF);

   function automatic int elem_off(input int r, input int c, input int w,
                                   input int max_n = c_MAX_N_DEF);
      return w * (r * max_n + c);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mpu_mac.sv
`default_nettype none
// ============================================================================
// Module      : mpu_mac
// Description : Signed multiply-accumulate with add/sub/product bypass modes.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_mac
   import mpu_pkg::*;
#(
   parameter int DATA_W = c_DATA_W_DEF,
   parameter int ACC_W  = 16,
   parameter int AW     = c_ACC_EXACT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  mpu_mode_t                i_mode,
   input  logic signed [DATA_W-1:0] i_a,
   input  logic signed [DATA_W-1:0] i_b,
   output logic signed [AW-1:0]     o_sum,
   output logic                     o_ovf
);

   logic signed [2*DATA_W-1:0] w_prod;
   logic signed [AW-1:0]       w_base;
   logic signed [AW-1:0]       r_acc;

   assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

   always_comb begin
      w_base = i_clr ? '0 : r_acc;
      case (i_mode)
         MODE_MUL: o_sum = w_base + AW'(w_prod);
         MODE_ADD: o_sum = AW'(i_a) + AW'(i_b);
         MODE_SUB: o_sum = AW'(i_a) - AW'(i_b);
         default:  o_sum = AW'(w_prod);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= o_sum;
      end
   end

   // Value fits ACC_W when all bits from the ACC_W sign bit upward agree
   generate
      if (AW > ACC_W) begin : g_ovf
         assign o_ovf = !((&o_sum[AW-1:ACC_W-1]) || (~|o_sum[AW-1:ACC_W-1]));
      end else begin : g_no_ovf
         assign o_ovf = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mpu_seq_matmul.sv
`default_nettype none
// ============================================================================
// Module      : mpu_seq_matmul
// Description : Sequential MUL/ADD/SUB/HAD matrix unit on one MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_seq_matmul
   import mpu_pkg::*;
#(
   parameter int MAX_N  = 5,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic [1:0]                        mode,
   input  logic [$clog2(MAX_N+1)-1:0]        size,
   input  logic [0:DATA_W*MAX_N*MAX_N-1]     matrix_a,
   input  logic [0:DATA_W*MAX_N*MAX_N-1]     matrix_b,
   output logic [0:ACC_W*MAX_N*MAX_N-1]      result,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic                              overflow
);

   localparam int c_SW     = $clog2(MAX_N+1);
   localparam int c_AW     = acc_exact_w(DATA_W, MAX_N);
   localparam int c_NE     = MAX_N * MAX_N;
   localparam int c_AOFF_W = $clog2(DATA_W * c_NE);
   localparam int c_ROFF_W = $clog2(ACC_W * c_NE);

   mpu_state_t                 r_state;
   mpu_state_t                 w_next;
   mpu_mode_t                  r_mode;
   logic [0:DATA_W*c_NE-1]     r_a;
   logic [0:DATA_W*c_NE-1]     r_b;
   logic [0:ACC_W*c_NE-1]      r_result;
   logic [c_SW-1:0]            r_nm1;
   logic [c_SW-1:0]            r_i;
   logic [c_SW-1:0]            r_j;
   logic [c_SW-1:0]            r_k;
   logic                       r_err;
   logic                       r_ovf;

   logic                       w_size_ok;
   logic                       w_is_mul;
   logic                       w_last_i;
   logic                       w_last_j;
   logic                       w_last_k;
   logic                       w_last;
   logic                       w_write;
   logic [c_SW-1:0]            w_acol;
   logic [c_SW-1:0]            w_brow;
   logic [c_AOFF_W-1:0]        w_aoff;
   logic [c_AOFF_W-1:0]        w_boff;
   logic [c_ROFF_W-1:0]        w_roff;
   logic signed [DATA_W-1:0]   w_a;
   logic signed [DATA_W-1:0]   w_b;
   logic signed [c_AW-1:0]     w_sum;
   logic                       w_ovf;

   assign w_size_ok = (size != '0) && (size <= c_SW'(MAX_N));
   assign w_is_mul  = (r_mode == MODE_MUL);
   assign w_last_i  = (r_i == r_nm1);
   assign w_last_j  = (r_j == r_nm1);
   assign w_last_k  = (r_k == r_nm1);
   assign w_last    = w_last_i && w_last_j && (!w_is_mul || w_last_k);
   assign w_write   = busy && (!w_is_mul || w_last_k);

   // MUL walks a[i][k]*b[k][j]; element-wise modes read a[i][j], b[i][j]
   assign w_acol = w_is_mul ? r_k : r_j;
   assign w_brow = w_is_mul ? r_k : r_i;
   assign w_aoff = c_AOFF_W'(elem_off(int'(r_i), int'(w_acol), DATA_W, MAX_N));
   assign w_boff = c_AOFF_W'(elem_off(int'(w_brow), int'(r_j), DATA_W, MAX_N));
   assign w_roff = c_ROFF_W'(elem_off(int'(r_i), int'(r_j), ACC_W, MAX_N));
   assign w_a    = r_a[w_aoff +: DATA_W];
   assign w_b    = r_b[w_boff +: DATA_W];

   mpu_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .AW     (c_AW)
   ) u_mac (
      .clk    (clock),
      .rst    (reset),
      .i_en   (busy && w_is_mul),
      .i_clr  (r_k == '0),
      .i_mode (r_mode),
      .i_a    (w_a),
      .i_b    (w_b),
      .o_sum  (w_sum),
      .o_ovf  (w_ovf)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = w_size_ok ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_mode   <= MODE_MUL;
         r_nm1    <= '0;
         r_i      <= '0;
         r_j      <= '0;
         r_k      <= '0;
         r_err    <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a      <= matrix_a;
                  r_b      <= matrix_b;
                  r_mode   <= mpu_mode_t'(mode);
                  r_nm1    <= size - 1'b1;
                  r_err    <= !w_size_ok;
                  r_result <= '0;
                  r_ovf    <= 1'b0;
                  r_i      <= '0;
                  r_j      <= '0;
                  r_k      <= '0;
               end
            end
            ST_RUN: begin
               if (w_write) begin
                  r_result[w_roff +: ACC_W] <= ACC_W'(w_sum);
                  if (w_ovf) begin
                     r_ovf <= 1'b1;
                  end
               end
               if (w_is_mul && !w_last_k) begin
                  r_k <= r_k + 1'b1;
               end else begin
                  r_k <= '0;
                  if (!w_last_j) begin
                     r_j <= r_j + 1'b1;
                  end else begin
                     r_j <= '0;
                     r_i <= w_last_i ? '0 : r_i + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign result   = r_result;
   assign error    = done & r_err;
   assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mpu_seq_matmul.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_seq_matmul
// Description : Directed self-checking bench for mpu_seq_matmul.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_seq_matmul;

   localparam int N  = 5;
   localparam int DW = 8;
   localparam int AW = 16;

   logic                clock = 1'b0;
   logic                reset;
   logic                start;
   logic [1:0]          mode;
   logic [2:0]          size;
   logic [0:DW*N*N-1]   ma;
   logic [0:DW*N*N-1]   mb;
   logic [0:AW*N*N-1]   result;
   logic                busy;
   logic                done;
   logic                error;
   logic                overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   mpu_seq_matmul #(.MAX_N(N), .DATA_W(DW), .ACC_W(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .mode     (mode),
      .size     (size),
      .matrix_a (ma),
      .matrix_b (mb),
      .result   (result),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .overflow (overflow)
   );

   task automatic set_a(input int r, input int c, input int v);
      ma[DW*(r*N+c) +: DW] = v[DW-1:0];
   endtask

   task automatic set_b(input int r, input int c, input int v);
      mb[DW*(r*N+c) +: DW] = v[DW-1:0];
   endtask

   function automatic int get_r(input int r, input int c);
      logic signed [AW-1:0] t;
      t = result[AW*(r*N+c) +: AW];
      return int'(t);
   endfunction

   // Count of elements outside the active n x n block that are nonzero
   function automatic int nz_outside(input int n);
      int cnt = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if ((r >= n || c >= n) && get_r(r, c) != 0) cnt++;
      return cnt;
   endfunction

   task automatic load_2x2();
      ma = '0; mb = '0;
      set_a(0, 0, 1); set_a(0, 1, 2); set_a(1, 0, 3); set_a(1, 1, 4);
      set_b(0, 0, 5); set_b(0, 1, 6); set_b(1, 0, 7); set_b(1, 1, 8);
   endtask

   // Issue one start; scramble inputs after capture; return cycles to done (-1 on timeout)
   task automatic run_op(input logic [1:0] m, input logic [2:0] n, input int mid_start,
                         output int cyc);
      logic [0:DW*N*N-1] sa, sb;
      @(negedge clock);
      while (done === 1'b1) @(negedge clock);
      mode = m; size = n; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; sa = ma; sb = mb; ma = ~ma; mb = ~mb; mode = ~m;
      cyc = 1;
      while (done !== 1'b1 && cyc < 400) begin
         start = (cyc == mid_start);
         @(posedge clock); #1;
         cyc++;
      end
      start = 1'b0; ma = sa; mb = sb;
      if (done !== 1'b1) cyc = -1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mode = 2'd0; size = 3'd0; ma = '0; mb = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
      checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
      @(negedge clock); reset = 1'b0;
   endtask

   task automatic test_mul_2x2();
      int cyc;
      load_2x2();
      run_op(2'd0, 3'd2, 0, cyc);
      checks++; if (cyc !== 9) begin failures++; $display("FAIL mul2_latency got=%0d exp=9", cyc); end
      checks++; if (busy !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL mul2_flags busy=%b error=%b exp=0,0", busy, error); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mul2_ovf got=%b exp=0", overflow); end
      checks++; if (get_r(0, 0) !== 19) begin failures++; $display("FAIL mul2_r00 got=%0d exp=19", get_r(0, 0)); end
      checks++; if (get_r(0, 1) !== 22) begin failures++; $display("FAIL mul2_r01 got=%0d exp=22", get_r(0, 1)); end
      checks++; if (get_r(1, 0) !== 43) begin failures++; $display("FAIL mul2_r10 got=%0d exp=43", get_r(1, 0)); end
      checks++; if (get_r(1, 1) !== 50) begin failures++; $display("FAIL mul2_r11 got=%0d exp=50", get_r(1, 1)); end
      checks++; if (nz_outside(2) !== 0) begin failures++; $display("FAIL mul2_outside nonzero=%0d exp=0", nz_outside(2)); end
   endtask

   task automatic test_mul_identity();
      int cyc, bad;
      ma = '0; mb = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            set_a(r, c, r*N + c + 1);
            set_b(r, c, (r == c) ? 1 : 0);
         end
      run_op(2'd0, 3'd5, 0, cyc);
      bad = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (get_r(r, c) != r*N + c + 1) bad++;
      checks++; if (cyc !== 126) begin failures++; $display("FAIL mulid_latency got=%0d exp=126", cyc); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL mulid_values wrong=%0d exp=0 r44=%0d", bad, get_r(4, 4)); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL mulid_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_mul_overflow();
      int cyc, bad;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            set_a(r, c, 127); set_b(r, c, 127);
         end
      run_op(2'd0, 3'd5, 0, cyc);
      bad = 0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            if (get_r(r, c) != 15109) bad++;
      checks++; if (cyc !== 126) begin failures++; $display("FAIL mulovf_latency got=%0d exp=126", cyc); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL mulovf_values wrong=%0d exp=0 r00=%0d", bad, get_r(0, 0)); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL mulovf_flag got=%b exp=1", overflow); end
   endtask

   task automatic test_elementwise();
      int cyc, bad;
      int expv [3] = '{-256, 0, 16384};
      for (int m = 1; m <= 3; m++) begin
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
               set_a(r, c, -128); set_b(r, c, -128);
            end
         run_op(2'(m), 3'd3, 0, cyc);
         bad = 0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               if (get_r(r, c) != expv[m-1]) bad++;
         checks++; if (cyc !== 10) begin failures++; $display("FAIL ew%0d_latency got=%0d exp=10", m, cyc); end
         checks++; if (bad !== 0) begin failures++; $display("FAIL ew%0d_values wrong=%0d r00=%0d exp=%0d", m, bad, get_r(0, 0), expv[m-1]); end
         checks++; if (nz_outside(3) !== 0) begin failures++; $display("FAIL ew%0d_outside nonzero=%0d exp=0", m, nz_outside(3)); end
         checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ew%0d_ovf got=%b exp=0", m, overflow); end
      end
   endtask

   task automatic test_bad_size();
      int cyc;
      logic [2:0] sizes [3] = '{3'd0, 3'd6, 3'd7};
      for (int s = 0; s < 3; s++) begin
         run_op(2'd0, sizes[s], 0, cyc);
         checks++; if (cyc !== 1) begin failures++; $display("FAIL bad%0d_latency got=%0d exp=1", sizes[s], cyc); end
         checks++; if (error !== 1'b1) begin failures++; $display("FAIL bad%0d_error got=%b exp=1", sizes[s], error); end
         checks++; if (result !== '0) begin failures++; $display("FAIL bad%0d_result got=%h exp=0", sizes[s], result); end
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      load_2x2();
      run_op(2'd0, 3'd2, 3, cyc);
      checks++; if (cyc !== 9) begin failures++; $display("FAIL ign_latency got=%0d exp=9", cyc); end
      checks++; if (get_r(0, 1) !== 22 || get_r(1, 0) !== 43) begin failures++; $display("FAIL ign_values r01=%0d r10=%0d exp=22,43", get_r(0, 1), get_r(1, 0)); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL ign_error got=%b exp=0", error); end
   endtask

   task automatic test_back_to_back();
      int cyc = 1, d1 = 0, d2 = 0;
      logic b10 = 1'bx;
      load_2x2();
      @(negedge clock);
      while (done === 1'b1) @(negedge clock);
      mode = 2'd0; size = 3'd2; start = 1'b1;
      @(posedge clock); #1;
      while (cyc < 60 && d2 == 0) begin
         if (done === 1'b1) begin
            if (d1 == 0) begin d1 = cyc; mode = 2'd1; end
            else d2 = cyc;
         end
         if (cyc == 10) b10 = busy;
         if (d2 == 0) begin @(posedge clock); #1; cyc++; end
      end
      start = 1'b0;
      checks++; if (d1 !== 9) begin failures++; $display("FAIL b2b_first_done got=%0d exp=9", d1); end
      checks++; if (d2 !== 15) begin failures++; $display("FAIL b2b_second_done got=%0d exp=15", d2); end
      checks++; if (b10 !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", b10); end
      checks++; if (get_r(0, 0) !== 6 || get_r(1, 1) !== 12) begin failures++; $display("FAIL b2b_add r00=%0d r11=%0d exp=6,12", get_r(0, 0), get_r(1, 1)); end
   endtask

   task automatic test_reset_mid_run();
      int cyc = 1, dn = 0, bz = 0;
      ma = '0; mb = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            set_a(r, c, 1); set_b(r, c, 1);
         end
      @(negedge clock);
      while (done === 1'b1) @(negedge clock);
      mode = 2'd0; size = 3'd4; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      while (cyc < 20) begin @(posedge clock); #1; cyc++; end
      checks++; if (busy !== 1'b1 || get_r(0, 0) !== 4) begin failures++; $display("FAIL rmid_pre busy=%b r00=%0d exp=1,4", busy, get_r(0, 0)); end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmid_flags busy=%b done=%b exp=0,0", busy, done); end
      checks++; if (result !== '0) begin failures++; $display("FAIL rmid_result got=%h exp=0", result); end
      repeat (80) begin
         @(posedge clock); #1;
         if (done === 1'b1) dn++;
         if (busy === 1'b1) bz++;
      end
      checks++; if (dn !== 0 || bz !== 0) begin failures++; $display("FAIL rmid_quiet done_cycles=%0d busy_cycles=%0d exp=0,0", dn, bz); end
      load_2x2();
      run_op(2'd0, 3'd2, 0, cyc);
      checks++; if (cyc !== 9 || get_r(1, 1) !== 50) begin failures++; $display("FAIL rmid_fresh latency=%0d r11=%0d exp=9,50", cyc, get_r(1, 1)); end
   endtask

   initial begin
      test_reset();
      test_mul_2x2();
      test_mul_identity();
      test_mul_overflow();
      test_elementwise();
      test_bad_size();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
